psum_requantizer: RTL
=====================

PSUM_REQUANTIZER -- requirements
Module: psum_requantizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, output element width (signed).
REQ-002 SHALL have parameter ACC_WIDTH, default 32, incoming partial-sum width (signed two's complement).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, input buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports psum_in  input  ACC_WIDTH  partial sum from PE column, and psum_valid_in  input  1  sample strobe (no backpressure to source).
REQ-007 SHALL have ports scale_mult  input  16  unsigned multiplier; shift  input  5  right-shift amount; zero_point  input  DATA_WIDTH  signed offset; relu_en  input  1  clamp negatives.
REQ-008 SHALL have port tile_len  input  16  outputs per tile; 0 disables tile_done.
REQ-009 SHALL have ports data_out  output  DATA_WIDTH  requantized element; valid_out  output  1; ready_in  input  1  downstream accept.
REQ-010 SHALL have ports tile_done  output  1  one-cycle pulse; overflow  output  1  sticky drop flag; clear_status  input  1  clears overflow and tile count.

Function
REQ-011 SHALL buffer samples in a FIFO_DEPTH-entry FIFO; push when psum_valid_in and (not full or pop same cycle).
REQ-012 SHALL drop a sample presented while full with no same-cycle pop, and set overflow on the following edge.
REQ-013 SHALL process via two register stages: A = multiply, B = round/offset/clamp; B drives data_out/valid_out.
REQ-014 SHALL compute stage A product as signed(psum) x zero-extended scale_mult, width ACC_WIDTH+17, no truncation.
REQ-015 SHALL compute stage B: r = (prod + (shift>0 ? 2^(shift-1) : 0)) arithmetic-shift-right shift; if relu_en and r<0 then r=0; r += zero_point; saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-016 SHALL sample config inputs as the sample enters stage A (first) and stage B (rest); changes take effect per sample.
REQ-017 SHALL hold data_out stable while valid_out=1 and ready_in=0; whole pipeline stalls in lockstep.
REQ-018 SHALL advance a stage when its downstream is empty or consuming the same cycle (bubble collapse).
REQ-019 SHALL give latency 3: psum_valid_in in cycle N (FIFO empty, ready_in=1) -> valid_out in cycle N+3; sustained throughput 1/cycle.
REQ-020 SHALL count output handshakes (valid_out and ready_in); on handshake completing count tile_len, pulse tile_done next cycle and wrap count to 0.
REQ-021 SHALL, on clear_status, clear overflow and tile count; if simultaneous with an overflow drop, overflow ends set; if simultaneous with a handshake, count ends at 0.
REQ-022 SHALL preserve sample order; no duplication; no loss except REQ-012.

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, empty FIFO, invalidate stages A/B, zero tile count.
REQ-024 SHALL hold data_out=0, valid_out=0, tile_done=0, overflow=0 during and after reset until new activity.
REQ-025 SHALL discard all in-flight samples on reset mid-stream; first post-reset sample follows REQ-019 timing.

Structure
REQ-026 SHALL place default widths, FIFO_DEPTH default and a requant-config struct (scale, shift, zero_point, relu_en) in the shared accelerator package.
REQ-027 SHALL implement the buffer as sub-module sync_fifo (parameterised width/depth, full/empty/count).
REQ-028 SHALL implement rounding/saturation as a package function, reusable by other output paths.

Verification
REQ-029 SHALL cover: psum=1000, scale=1, shift=4, zp=0, relu=0 -> data_out=63 at cycle N+3.
REQ-030 SHALL cover: psum=100000, scale=1, shift=0 -> 127; psum=-100000 -> -128 (0x80).
REQ-031 SHALL cover: psum=-500, scale=1, shift=2, relu=0 -> -125 (0x83); same with relu=1, zp=5 -> 5.
REQ-032 SHALL cover: ready_in=0, 12 back-to-back samples, depth 8 -> first 10 later emitted in order, samples 11-12 dropped, overflow=1 until clear_status.
REQ-033 SHALL cover: tile_len=4, 9 outputs with random ready_in stalls -> tile_done pulses after handshakes 4 and 8 only.
REQ-034 SHALL cover: rst_n low for 1 cycle with 5 samples in flight -> valid_out=0 next cycle, no stale output afterwards.

Source files
------------

// File: rtl/psum_requantizer_pkg.sv
// Shared accelerator definitions: default widths, the requantisation config
// record and the round/offset/clamp helper used by every output path.
package psum_requantizer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 32;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Widest product / zero point the helper accepts (ACC_WIDTH + 17 <= 64).
  localparam int PROD_MAX_WIDTH = 64;
  localparam int ZP_MAX_WIDTH   = 16;

  typedef struct packed {
    logic [15:0]                    scale;
    logic [4:0]                     shift;
    logic signed [ZP_MAX_WIDTH-1:0] zero_point;
    logic                           relu_en;
  } requant_cfg_t;

  // Round-half-up right shift, optional ReLU, zero-point add, then saturate
  // to a signed data_width-bit range. Result is returned sign-extended.
  function automatic logic signed [31:0] requant_round_sat(
    input logic signed [PROD_MAX_WIDTH-1:0] prod,
    input logic [4:0]                       shift,
    input logic signed [ZP_MAX_WIDTH-1:0]   zero_point,
    input logic                             relu_en,
    input int                               data_width
  );
    logic signed [PROD_MAX_WIDTH:0] one;
    logic signed [PROD_MAX_WIDTH:0] half;
    logic signed [PROD_MAX_WIDTH:0] r;
    logic signed [PROD_MAX_WIDTH:0] max_val;
    logic signed [PROD_MAX_WIDTH:0] min_val;
    one    = '0;
    one[0] = 1'b1;
    half   = '0;
    if (shift != 5'd0) begin
      half = one <<< (shift - 5'd1);
    end
    // One guard bit above the product keeps the rounding add from wrapping.
    r = (PROD_MAX_WIDTH + 1)'(prod) + half;
    r = r >>> shift;
    if (relu_en && (r < 0)) begin
      r = '0;
    end
    r       = r + (PROD_MAX_WIDTH + 1)'(zero_point);
    max_val = (one <<< (data_width - 1)) - one;
    min_val = -(one <<< (data_width - 1));
    if (r > max_val) begin
      r = max_val;
    end else if (r < min_val) begin
      r = min_val;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/psum_requantizer_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read so a buffered sample
// can enter the multiply stage in the cycle after it was written.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign rdata = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  // Pointer advance; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_requantizer.sv
// Partial-sum requantiser: input FIFO, multiply stage, round/offset/clamp
// stage with ready/valid output, tile completion pulse and drop flag.
module psum_requantizer
  import psum_requantizer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ACC_WIDTH-1:0]         psum_in,
  input  logic                         psum_valid_in,
  input  logic [15:0]                  scale_mult,
  input  logic [4:0]                   shift,
  input  logic signed [DATA_WIDTH-1:0] zero_point,
  input  logic                         relu_en,
  input  logic [15:0]                  tile_len,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         tile_done,
  output logic                         overflow,
  input  logic                         clear_status
);

  localparam int PROD_WIDTH = ACC_WIDTH + 17;
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;

  requant_cfg_t                  cfg;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [CNT_WIDTH-1:0]          fifo_count;
  logic [ACC_WIDTH-1:0]          fifo_rdata;
  logic                          push;
  logic                          pop;
  logic                          drop;
  logic                          a_ready;
  logic                          b_ready;
  logic                          handshake;
  logic                          a_valid_reg;
  logic signed [PROD_WIDTH-1:0]  a_prod_reg;
  logic signed [PROD_WIDTH-1:0]  a_prod_next;
  logic [15:0]                   tile_cnt_reg;
  logic [15:0]                   tile_cnt_next;
  logic                          tile_hit;

  // Live configuration gathered into the shared record.
  always_comb begin
    cfg            = '0;
    cfg.scale      = scale_mult;
    cfg.shift      = shift;
    cfg.zero_point = ZP_MAX_WIDTH'(zero_point);
    cfg.relu_en    = relu_en;
  end

  // A stage may load when it is empty or its successor takes its contents.
  assign b_ready   = !valid_out || ready_in;
  assign a_ready   = !a_valid_reg || b_ready;
  assign pop       = !fifo_empty && a_ready;
  assign push      = psum_valid_in && ((fifo_count != CNT_WIDTH'(FIFO_DEPTH)) || pop);
  assign drop      = psum_valid_in && fifo_full && !pop;
  assign handshake = valid_out && ready_in;

  assign a_prod_next = PROD_WIDTH'($signed(fifo_rdata)) *
                       PROD_WIDTH'($signed({1'b0, cfg.scale}));

  sync_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (psum_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage A: full-precision product, scale captured as the sample enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_reg <= 1'b0;
      a_prod_reg  <= '0;
    end else if (a_ready) begin
      a_valid_reg <= pop;
      if (pop) begin
        a_prod_reg <= a_prod_next;
      end
    end
  end

  // Stage B: round, ReLU, offset and saturate; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (b_ready) begin
      valid_out <= a_valid_reg;
      if (a_valid_reg) begin
        data_out <= DATA_WIDTH'(requant_round_sat(PROD_MAX_WIDTH'(a_prod_reg),
                                                  cfg.shift, cfg.zero_point,
                                                  cfg.relu_en, DATA_WIDTH));
      end
    end
  end

  assign tile_cnt_next = tile_cnt_reg + 16'd1;
  assign tile_hit      = (tile_len != 16'd0) && (tile_cnt_next == tile_len);

  // Handshake counter with tile wrap; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_cnt_reg <= '0;
      tile_done    <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (clear_status) begin
        tile_cnt_reg <= '0;
      end else if (handshake) begin
        if (tile_hit) begin
          tile_cnt_reg <= '0;
          tile_done    <= 1'b1;
        end else begin
          tile_cnt_reg <= tile_cnt_next;
        end
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_status) begin
      overflow <= 1'b0;
    end
  end

endmodule
